// File: rtl/counter_bank_with_strobe.sv
//==============================================================================
// Module   : counter_bank_with_strobe
// Summary  : CHANNELS independent enable-tick counters. Each has a programmable
//            period, a periodic or one-shot mode and a registered one-cycle strobe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_bank_with_strobe #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 8,
  parameter int RESET_PERIOD = 2,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] armed,
  output logic                strobe_any
);

  localparam logic [WIDTH-1:0] c_reset_period = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] c_one          = WIDTH'(1);

  logic [CHANNELS-1:0] w_next_strobe;
  logic                r_strobe_any;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] r_period;
      logic [WIDTH-1:0] r_count;
      logic             r_oneshot;
      logic             r_armed;
      logic             r_strobe;
      logic             w_sel;
      logic             w_count_en;
      logic             w_hit;

      // A matching select implies an in-range address, so no separate range check.
      assign w_sel      = cfg_we && (cfg_ch == CH_W'(i));
      // A zero period never counts, which keeps count pinned at 1.
      assign w_count_en = enable[i] && r_armed && (r_period != '0);
      assign w_hit      = w_count_en && (r_count == r_period);

      assign w_next_strobe[i] = w_hit && !w_sel;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_period  <= c_reset_period;
          r_count   <= c_one;
          r_oneshot <= 1'b0;
          r_armed   <= 1'b1;
          r_strobe  <= 1'b0;
        end else if (w_sel) begin
          r_period  <= cfg_period;
          r_oneshot <= cfg_oneshot;
          r_count   <= c_one;
          r_armed   <= 1'b1;
          r_strobe  <= 1'b0;
        end else begin
          r_strobe <= w_hit;
          if (w_count_en) begin
            if (w_hit) begin
              r_count <= c_one;
              if (r_oneshot) begin
                r_armed <= 1'b0;
              end
            end else begin
              r_count <= r_count + c_one;
            end
          end
        end
      end

      assign strobe[i] = r_strobe;
      assign armed[i]  = r_armed;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strobe_any <= 1'b0;
    end else begin
      r_strobe_any <= |w_next_strobe;
    end
  end

  assign strobe_any = r_strobe_any;

endmodule

`default_nettype wire

// File: tb/tb_counter_bank_with_strobe.sv
//==============================================================================
// Module   : tb_counter_bank_with_strobe
// Summary  : Directed and random stimulus against an event-counting reference
//            model; a 3-channel copy exercises out-of-range channel writes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_counter_bank_with_strobe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] enable;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_oneshot;
  logic [3:0] strobe, armed;
  logic       strobe_any;
  logic [2:0] strobe3, armed3;
  logic       strobe_any3;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: [instance][channel]; instance 0 has 4 channels, instance 1 has 3.
  int m_per [2][4];
  bit m_os  [2][4];
  int m_seen[2][4];
  bit m_arm [2][4];
  bit m_stb [2][4];
  int s_cnt [4];

  always #5 clk = ~clk;

  counter_bank_with_strobe #(.CHANNELS(4), .WIDTH(8), .RESET_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .strobe(strobe), .armed(armed), .strobe_any(strobe_any)
  );

  counter_bank_with_strobe #(.CHANNELS(3), .WIDTH(8), .RESET_PERIOD(2)) dut3 (
    .clk(clk), .rst(rst), .enable(enable[2:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .strobe(strobe3), .armed(armed3), .strobe_any(strobe_any3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        m_per[k][c] = 2; m_os[k][c] = 0; m_seen[k][c] = 0;
        m_arm[k][c] = 1; m_stb[k][c] = 0;
      end
  endtask

  // Each channel counts accepted enables since its last load or strobe;
  // reaching the period produces a strobe and restarts the tally.
  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < nch(k); c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_per[k][c] = int'(cfg_period); m_os[k][c] = cfg_oneshot;
          m_seen[k][c] = 0; m_arm[k][c] = 1; m_stb[k][c] = 0;
        end else begin
          m_stb[k][c] = 0;
          if (enable[c] && m_arm[k][c] && m_per[k][c] != 0) begin
            m_seen[k][c]++;
            if (m_seen[k][c] == m_per[k][c]) begin
              m_stb[k][c] = 1;
              m_seen[k][c] = 0;
              if (m_os[k][c]) m_arm[k][c] = 0;
            end
          end
        end
      end
  endtask

  function automatic logic [3:0] vec_stb(input int k);
    logic [3:0] v = '0;
    for (int c = 0; c < nch(k); c++) v[c] = m_stb[k][c];
    return v;
  endfunction

  function automatic logic [3:0] vec_arm(input int k);
    logic [3:0] v = '0;
    for (int c = 0; c < nch(k); c++) v[c] = m_arm[k][c];
    return v;
  endfunction

  task automatic compare_all();
    check("strobe", {28'd0, strobe}, {28'd0, vec_stb(0)});
    check("armed", {28'd0, armed}, {28'd0, vec_arm(0)});
    check("strobe_any", {31'd0, strobe_any}, {31'd0, |vec_stb(0)});
    check("strobe3", {29'd0, strobe3}, {28'd0, vec_stb(1)});
    check("armed3", {29'd0, armed3}, {28'd0, vec_arm(1)});
    check("strobe_any3", {31'd0, strobe_any3}, {31'd0, |vec_stb(1)});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    for (int c = 0; c < 4; c++) if (strobe[c]) s_cnt[c]++;
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < 4; c++) s_cnt[c] = 0;
  endtask

  task automatic wr(input int ch, input int per, input bit os);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(per); cfg_oneshot = os;
    enable = '0;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic en(input logic [3:0] mask, input int n);
    enable = mask;
    repeat (n) cycle();
    enable = '0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b0; enable = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
    model_reset();
    clr_cnt();
    repeat (3) cycle();
    check("reset_strobe", {28'd0, strobe}, 32'd0);
    check("reset_armed", {28'd0, armed}, 32'hf);

    // Reset defaults: period 2 on channel 0
    rst = 1'b1;
    clr_cnt();
    en(4'b0001, 6);
    cycle();
    check("t1_ch0_strobes", s_cnt[0], 3);
    check("t1_other_strobes", s_cnt[1] + s_cnt[2] + s_cnt[3], 0);

    // Programmed period with gaps in the enable stream
    wr(1, 5, 0);
    clr_cnt();
    pat = 8'b1100_1101;
    for (int b = 0; b < 8; b++) begin
      enable = {2'b00, pat[b], 1'b0};
      cycle();
    end
    enable = '0;
    cycle();
    check("t2_ch1_strobes", s_cnt[1], 1);

    // One-shot fires once, then re-arms on rewrite
    wr(2, 3, 1);
    clr_cnt();
    en(4'b0100, 10);
    cycle();
    check("t3_oneshot_strobes", s_cnt[2], 1);
    check("t3_disarmed", {31'd0, armed[2]}, 32'd0);
    wr(2, 3, 1);
    check("t3_rearmed", {31'd0, armed[2]}, 32'd1);
    clr_cnt();
    en(4'b0100, 3);
    cycle();
    check("t3_refire", s_cnt[2], 1);

    // Write collides with the would-be 4th enable
    wr(0, 4, 0);
    clr_cnt();
    en(4'b0001, 3);
    enable = 4'b0001; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 8'd2; cfg_oneshot = 1'b0;
    cycle();
    cfg_we = 1'b0;
    enable = '0;
    cycle();
    check("t4_dropped", s_cnt[0], 0);
    en(4'b0001, 2);
    cycle();
    check("t4_after", s_cnt[0], 1);

    // Period boundaries on channel 3 (absent from the 3-channel copy)
    wr(3, 1, 0);
    clr_cnt();
    en(4'b1000, 5);
    cycle();
    check("t5_p1", s_cnt[3], 5);
    wr(3, 0, 0);
    clr_cnt();
    en(4'b1000, 300);
    cycle();
    check("t5_p0", s_cnt[3], 0);
    check("t5_p0_armed", {31'd0, armed[3]}, 32'd1);
    wr(3, 255, 0);
    clr_cnt();
    en(4'b1000, 510);
    cycle();
    check("t5_p255", s_cnt[3], 2);

    // Asynchronous reset while a strobe is high
    wr(1, 6, 0);
    en(4'b0010, 5);
    wr(3, 1, 0);
    enable = 4'b1000;
    cycle();
    check("t6_inflight", {31'd0, strobe[3]}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_strobe", {28'd0, strobe}, 32'd0);
    check("t6_async_any", {31'd0, strobe_any}, 32'd0);
    check("t6_async_armed", {28'd0, armed}, 32'hf);
    model_reset();
    enable = '0;
    #1 rst = 1'b1;
    clr_cnt();
    en(4'b0010, 2);
    cycle();
    check("t6_ch1_default", s_cnt[1], 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      enable = 4'($urandom);
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_ch = 2'($urandom);
      case ($urandom_range(0, 5))
        0: cfg_period = 8'd0;
        1: cfg_period = 8'd1;
        2: cfg_period = 8'd255;
        default: cfg_period = 8'($urandom_range(2, 9));
      endcase
      cfg_oneshot = 1'($urandom);
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      else rst = 1'b1;
      cycle();
    end
    rst = 1'b1; cfg_we = 1'b0; enable = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
